// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types, constants and helpers for the arbitrated binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

   localparam int unsigned             DIGIT_W    = 4;
   localparam logic [DIGIT_W-1:0]      ADJ_THRESH = DIGIT_W'(5);
   localparam logic [DIGIT_W-1:0]      ADJ_ADD    = DIGIT_W'(3);
   localparam int unsigned             BCD_MAX_W  = 256;

   typedef logic [BCD_MAX_W-1:0] bcd_vec_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r++;
      end
      return r;
   endfunction

   // Digits that are still zero stay zero, so callers may zero-extend into the wide vector.
   function automatic bcd_vec_t digit_adjust(input bcd_vec_t v);
      bcd_vec_t r;
      r = v;
      for (int unsigned d = 0; d < BCD_MAX_W / DIGIT_W; d++) begin
         if (v[d*DIGIT_W +: DIGIT_W] >= ADJ_THRESH)
            r[d*DIGIT_W +: DIGIT_W] = v[d*DIGIT_W +: DIGIT_W] + ADJ_ADD;
      end
      return r;
   endfunction

   function automatic bit digits_cover(input int unsigned data_w, input int unsigned digits);
      logic [BCD_MAX_W:0] p10;
      logic [BCD_MAX_W:0] p2;
      if (digits * DIGIT_W > BCD_MAX_W || data_w >= BCD_MAX_W)
         return 1'b0;
      p10 = (BCD_MAX_W+1)'(1);
      for (int unsigned i = 0; i < digits; i++)
         p10 = p10 * (BCD_MAX_W+1)'(10);
      p2 = '0;
      p2[data_w] = 1'b1;
      return p10 > p2;
   endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bundle between requesters, the shared converter and the result consumer.
interface bcd_conv_arbiter_if
   import bcd_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 30,
   parameter int unsigned DIGITS  = 10
);
   localparam int unsigned ID_W = clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [DIGITS*DIGIT_W-1:0] rsp_bcd;
   logic                      busy;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_bcd, busy
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_bcd, busy
   );

endinterface

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr_i, wrapping.
module bcd_rr_pick
   import bcd_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    idx_o
);

   logic            found;
   logic [ID_W-1:0] cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((32'(ptr_i) + k) % NUM_REQ);
         if (!found && valid_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one iterative shift-add-3 binary-to-BCD datapath among NUM_REQ round-robin requesters.
module bcd_conv_arbiter
   import bcd_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 30,
   parameter int unsigned DIGITS  = 10
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   bcd_conv_arbiter_if.slave  bus
);

   localparam int unsigned ID_W  = clog2(NUM_REQ);
   localparam int unsigned BCD_W = DIGITS * DIGIT_W;
   localparam int unsigned SR_W  = BCD_W + DATA_W;
   localparam int unsigned CNT_W = clog2(DATA_W + 1);

   if (NUM_REQ < 2) begin : g_chk_req
      $error("NUM_REQ must be at least 2");
   end
   if (!digits_cover(DATA_W, DIGITS)) begin : g_chk_digits
      $error("DIGITS cannot represent every DATA_W-bit operand");
   end

   state_t             state_q, state_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               accept;
   logic [DATA_W-1:0]  sel_data;
   logic [BCD_W-1:0]   adj_bcd;

   bcd_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .valid_i (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx)
   );

   always_comb begin
      accept   = (state_q == IDLE) && (|grant);
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i])
            sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
      adj_bcd = BCD_W'(digit_adjust(bcd_vec_t'(sr_q[SR_W-1 -: BCD_W])));
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         id_q    <= '0;
         ptr_q   <= ID_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sr_d    = {{BCD_W{1'b0}}, sel_data};
               id_d    = grant_idx;
               ptr_d   = grant_idx;
               cnt_d   = '0;
               state_d = ADJ;
            end
         end
         ADJ: begin
            sr_d    = {adj_bcd, sr_q[DATA_W-1:0]};
            state_d = SHIFT;
         end
         SHIFT: begin
            sr_d    = sr_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == CNT_W'(DATA_W)) ? DONE : ADJ;
         end
         DONE: begin
            if (bus.rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // After DATA_W shifts the operand has moved entirely into the BCD field, which stays frozen in DONE.
   always_comb begin
      bus.req_ready = (state_q == IDLE) ? grant : '0;
      bus.rsp_valid = (state_q == DONE);
      bus.rsp_bcd   = sr_q[SR_W-1 -: BCD_W];
      bus.rsp_id    = id_q;
      bus.busy      = (state_q != IDLE);
   end

endmodule
